// File: rtl/wb_gpio_pkg.sv
// Shared definitions for wb_gpio_bridge: register offsets, ack FSM states and byte-lane merge.
package wb_gpio_pkg;

   // Base offset of each LO/HI register pair; address bit 2 selects the HI word.
   localparam logic [5:0] OffOut  = 6'h00;
   localparam logic [5:0] OffOeb  = 6'h08;
   localparam logic [5:0] OffIn   = 6'h10;
   localparam logic [5:0] OffMask = 6'h18;
   localparam logic [5:0] OffStat = 6'h20;

   typedef enum logic [0:0] {
      StIdle,
      StAck
   } state_e;

   function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = sel[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_gpio_bridge_if.sv
// Wishbone classic slave signal bundle used by wb_gpio_bridge.
interface wb_gpio_bridge_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic [3:0]  wbs_sel_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/wb_gpio_sync.sv
// Per-pad input synchroniser followed by a prev flop; edge_o flags a synchronised rising edge.
module wb_gpio_sync #(
   parameter int unsigned Width      = 1,
   parameter int unsigned SyncStages = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] sync_o,
   output logic [Width-1:0] edge_o
);
   logic [SyncStages-1:0][Width-1:0] stage_q;
   logic [Width-1:0]                 prev_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stage_q <= '0;
         prev_q  <= '0;
      end else begin
         stage_q <= {stage_q[SyncStages-2:0], d_i};
         prev_q  <= stage_q[SyncStages-1];
      end
   end

   assign sync_o = stage_q[SyncStages-1];
   assign edge_o = stage_q[SyncStages-1] & ~prev_q;

endmodule

// File: rtl/wb_gpio_bridge.sv
// Wishbone-classic GPIO bridge for up to 64 pads; interrupt logic is built only when
// WB_GPIO_IRQ_EN is defined.
module wb_gpio_bridge
   import wb_gpio_pkg::*;
#(
   parameter int unsigned NUM_IO      = 38,
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   wb_gpio_bridge_if.slave   wbs,
   input  logic [NUM_IO-1:0] io_in,
   output logic [NUM_IO-1:0] io_out,
   output logic [NUM_IO-1:0] io_oeb,
   output logic [2:0]        user_irq
);
   state_e            state_q, state_d;
   logic              hit, req, wr, hi;
   logic [5:0]        pair_off;
   logic [NUM_IO-1:0] out_q, out_d, oeb_q, oeb_d, in_sync, pad_edge;
   logic [31:0]       rd_word, dat_q;

   // Registers are NUM_IO wide; these views pad them to a 64-bit LO/HI pair.
   function automatic logic [NUM_IO-1:0] merge_half(input logic [NUM_IO-1:0] old_v,
                                                    input logic              hi_h,
                                                    input logic [31:0]       dat,
                                                    input logic [3:0]        sel);
      logic [63:0] ext;
      ext = 64'(old_v);
      if (hi_h) ext[63:32] = lane_merge(ext[63:32], dat, sel);
      else      ext[31:0]  = lane_merge(ext[31:0], dat, sel);
      return ext[NUM_IO-1:0];
   endfunction

   function automatic logic [31:0] pick_half(input logic [NUM_IO-1:0] v, input logic hi_h);
      logic [63:0] ext;
      ext = 64'(v);
      return hi_h ? ext[63:32] : ext[31:0];
   endfunction

   assign hit      = wbs.wbs_adr_i[31:6] == BASE_ADDR[31:6];
   assign pair_off = {wbs.wbs_adr_i[5:3], 3'b000};
   assign hi       = wbs.wbs_adr_i[2];
   assign req      = (state_q == StIdle) && wbs.wbs_cyc_i && wbs.wbs_stb_i && hit;
   assign wr       = req && wbs.wbs_we_i;

   wb_gpio_sync #(
      .Width      (NUM_IO),
      .SyncStages (SYNC_STAGES)
   ) u_sync (
      .clk_i  (wb_clk_i),
      .rst_ni (wb_rst_ni),
      .d_i    (io_in),
      .sync_o (in_sync),
      .edge_o (pad_edge)
   );

`ifdef WB_GPIO_IRQ_EN
   localparam logic [2:0] WarmCycles = 3'(SYNC_STAGES + 1);

   logic [NUM_IO-1:0] mask_q, mask_d, stat_q, stat_d, w1c;
   logic [2:0]        warm_q;
   logic              warm_done, irq_q;

   // Holds off edge capture until the synchroniser has flushed its reset state.
   assign warm_done = warm_q == WarmCycles;

   always_comb begin
      mask_d = mask_q;
      w1c    = '0;
      if (wr && pair_off == OffMask) begin
         mask_d = merge_half(mask_q, hi, wbs.wbs_dat_i, wbs.wbs_sel_i);
      end
      if (wr && pair_off == OffStat) begin
         w1c = merge_half('0, hi, wbs.wbs_dat_i, wbs.wbs_sel_i);
      end
      // A new edge beats a clear of the same bit.
      stat_d = (stat_q & ~w1c) | (pad_edge & {NUM_IO{warm_done}});
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         mask_q <= '0;
         stat_q <= '0;
         warm_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         mask_q <= mask_d;
         stat_q <= stat_d;
         irq_q  <= |(stat_q & mask_q);
         if (!warm_done) warm_q <= warm_q + 3'd1;
      end
   end

   assign user_irq = {2'b00, irq_q};
`else
   assign user_irq = 3'b000;
`endif

   always_comb begin
      rd_word = '0;
      case (pair_off)
         OffOut:  rd_word = pick_half(out_q, hi);
         OffOeb:  rd_word = pick_half(oeb_q, hi);
         OffIn:   rd_word = pick_half(in_sync, hi);
`ifdef WB_GPIO_IRQ_EN
         OffMask: rd_word = pick_half(mask_q, hi);
         OffStat: rd_word = pick_half(stat_q, hi);
`endif
         default: rd_word = '0;
      endcase
   end

   always_comb begin
      out_d = out_q;
      oeb_d = oeb_q;
      if (wr && pair_off == OffOut) out_d = merge_half(out_q, hi, wbs.wbs_dat_i, wbs.wbs_sel_i);
      if (wr && pair_off == OffOeb) oeb_d = merge_half(oeb_q, hi, wbs.wbs_dat_i, wbs.wbs_sel_i);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (req) state_d = StAck;
         StAck:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_q <= StIdle;
         out_q   <= '0;
         oeb_q   <= '1;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         oeb_q   <= oeb_d;
         dat_q   <= req ? rd_word : '0;
      end
   end

   assign wbs.wbs_ack_o = state_q == StAck;
   assign wbs.wbs_dat_o = dat_q;
   assign io_out        = out_q;
   assign io_oeb        = oeb_q;

endmodule

// File: doc/wb_gpio_bridge.md
# wb_gpio_bridge

Parametrised Wishbone-classic slave giving the management SoC direct control of up to 64 user I/O pads, with input synchronisation and maskable rising-edge interrupts. It sits in the user project wrapper beside the core and owns the `io_out`/`io_oeb` pads not claimed by the core. It generalises the fixed pass-through wiring into a register-mapped, configurable-width bridge.

## Interface
- `NUM_IO`, 38: number of pads handled; legal range 1..64.
- `BASE_ADDR`, 32'h3000_0000: register window base; bits [31:6] are compared.
- `SYNC_STAGES`, 2: input synchroniser depth; legal range 2..3.
- `wb_clk_i` in 1: single clock.
- `wb_rst_ni` in 1: reset. Synchronous, active-low.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1: Wishbone classic control signals.
- `wbs_adr_i` in 32, `wbs_dat_i` in 32, `wbs_sel_i` in 4: address, write data, byte enables.
- `wbs_ack_o` out 1, `wbs_dat_o` out 32: acknowledge and read data.
- `io_in` in NUM_IO: pad inputs. Asynchronous to `wb_clk_i`.
- `io_out`, `io_oeb` out NUM_IO each: pad output value and active-low output enable.
- `user_irq` out 3: bit 0 is the GPIO interrupt; bits 2:1 are tied to 0.

## Operation
- Register map (byte offset; LO holds pads 31:0, HI holds pads 63:32):
  - 0x00/0x04 OUT: R/W.
  - 0x08/0x0C OEB: R/W.
  - 0x10/0x14 IN: read-only, synchronised value.
  - 0x18/0x1C MASK: R/W.
  - 0x20/0x24 STAT: read; write-1-to-clear.
- Register bits at or above NUM_IO read 0 and ignore writes. Offsets 0x28–0x3C ack, read 0, and ignore writes.
- Byte lanes: a write updates only the bytes whose `wbs_sel_i` bit is set.
- Address hit: `wbs_adr_i[31:6] == BASE_ADDR[31:6]`. On a miss there is no ack and no state change.
- Ack FSM, two states:
  - IDLE -> ACK when `cyc&stb&hit`.
  - ACK -> IDLE unconditionally.
  - The write is committed, and `wbs_dat_o` is loaded, on the IDLE->ACK edge.
  - `wbs_dat_o` is 0 whenever ack is low.
- Synchroniser: SYNC_STAGES flops per pad, followed by one `prev` flop.
- Edge detect: `edge = sync & ~prev`. The matching STAT bit sets on the following clock.
- STAT set vs W1C in the same cycle: set wins.
- `user_irq[0]` is a registered `|(STAT & MASK)`.
- Warm-up: a saturating counter suppresses edge detection for SYNC_STAGES+1 cycles after reset release, so pads already high at reset do not raise STAT.
- Reset values:
  - OUT, MASK, STAT, sync flops, `prev`: 0.
  - OEB: all ones (all pads are inputs).
  - `wbs_ack_o`, `wbs_dat_o`, `user_irq`: 0.
  - FSM: IDLE.
- Reset asserted mid-transaction: the FSM returns to IDLE, no ack is issued, and the pending write is dropped.

## Timing
- Ack latency: one cycle after the request. Ack is high for exactly one cycle.
- Back-to-back: a master holding `stb` sees an ack every other cycle, so one access per 2 cycles.
- Write to pad: `io_out`/`io_oeb` change on the same edge as ack rises.
- Input to IN readable: SYNC_STAGES edges.
- Input rise to STAT set: SYNC_STAGES+1 edges.
- Input rise to `user_irq[0]`: SYNC_STAGES+2 edges.
- A W1C that clears the last masked STAT bit drops `user_irq[0]` one edge after the write commits.

## Configuration
- `WB_GPIO_IRQ_EN` defined:
  - MASK/STAT registers, edge detect, warm-up counter and `user_irq[0]` are present.
- `WB_GPIO_IRQ_EN` undefined:
  - That logic is removed.
  - Offsets 0x18–0x24 read 0 and ignore writes.
  - `user_irq` is tied to 3'b000.
  - The synchroniser and IN register remain.

## Structure
- Package `wb_gpio_pkg` holds:
  - register offset localparams;
  - the FSM state enum (IDLE, ACK);
  - the lane-merge function (old, new, sel).
- Sub-module `wb_gpio_sync`: the per-pad synchroniser plus `prev` flop and edge output. It is parametrised by width and SYNC_STAGES and instantiated once.

## Test plan
- Reset then read OEB_LO -> 0xFFFF_FFFF; OEB_HI with NUM_IO=38 -> 0x0000_003F; `io_oeb` all 1, `io_out` 0.
- Write OUT_LO=0xA5A5_A5A5 with sel=4'b0011 -> readback 0x0000_A5A5; `io_out[15:0]` changes on the ack edge.
- Drive `io_in[37]` high with MASK_HI bit 5 set -> IN_HI=0x20 after 2 edges; STAT_HI bit 5 after 3 edges; `user_irq[0]` after 4 edges. Then write STAT_HI=0x20 -> irq low one edge later.
- Rising edge on the same cycle as a W1C of that bit -> STAT stays 1.
- Access with `wbs_adr_i`=0x3100_0000 -> no ack in 10 cycles, no register changes. Assert `wb_rst_ni` low during ACK -> ack drops the next edge and the write is lost.
- With `io_in`=all ones held through reset -> STAT stays 0 after the warm-up period.
